// File: rtl/mac4x16_dot_reduce.sv
// Dot-product reduction stage: sums unmasked MAC lane results over a group of
// beats terminated by in_last and emits one saturated AW-bit result per group.
module mac4x16_dot_reduce #(
  parameter int LANES = 4,
  parameter int AW    = 32,
  parameter int ACCW  = 40,
  parameter int CNTW  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*AW-1:0]   y_vec,
  input  logic [LANES-1:0]      lane_mask,
  input  logic                  op_signed,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [AW-1:0]         sum_out,
  output logic                  sat_flag,
  output logic [CNTW-1:0]       beat_count
);

  typedef enum logic {
    S_ACC,
    S_OUT
  } state_t;

  localparam logic [ACCW-1:0] ACC_MAX_S = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic [ACCW-1:0] ACC_MIN_S = {1'b1, {(ACCW-1){1'b0}}};
  localparam logic [AW-1:0]   OUT_MAX_S = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0]   OUT_MIN_S = {1'b1, {(AW-1){1'b0}}};

  state_t            state, state_next;
  logic [ACCW-1:0]   acc;
  logic              acc_ovf;
  logic [CNTW-1:0]   cnt;
  logic              grp_signed;

  logic              accept;
  logic              eff_signed;
  logic [ACCW-1:0]   lane_sum;
  logic [ACCW:0]     raw_sum;
  logic              ovf;
  logic [ACCW-1:0]   acc_sum;
  logic [CNTW-1:0]   cnt_inc;
  logic [ACCW-AW:0]  hi_bits;
  logic              clamp_hit;
  logic [AW-1:0]     sum_fin;

  assign out_valid  = (state == S_OUT);
  assign in_ready   = rst & (~out_valid | out_ready);
  assign accept     = in_valid & in_ready;
  // The first beat of a group decides signedness before grp_signed is loaded.
  assign eff_signed = (cnt == '0) ? op_signed : grp_signed;
  assign cnt_inc    = (cnt == '1) ? cnt : cnt + 1'b1;

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_mask[i]) begin
        lane_sum = lane_sum +
          {{(ACCW-AW){eff_signed & y_vec[i*AW+AW-1]}}, y_vec[i*AW +: AW]};
      end
    end
  end

  // Accumulator add with overflow clamped toward the direction it ran off.
  always_comb begin
    raw_sum = {1'b0, acc} + {1'b0, lane_sum};
    ovf     = 1'b0;
    acc_sum = raw_sum[ACCW-1:0];
    if (eff_signed) begin
      ovf = (acc[ACCW-1] == lane_sum[ACCW-1]) && (raw_sum[ACCW-1] != acc[ACCW-1]);
      if (ovf) acc_sum = acc[ACCW-1] ? ACC_MIN_S : ACC_MAX_S;
    end else begin
      ovf = raw_sum[ACCW];
      if (ovf) acc_sum = '1;
    end
  end

  always_comb begin
    hi_bits   = acc_sum[ACCW-1:AW-1];
    clamp_hit = 1'b0;
    sum_fin   = acc_sum[AW-1:0];
    if (eff_signed) begin
      clamp_hit = !((hi_bits == '0) || (hi_bits == '1));
      if (clamp_hit) sum_fin = acc_sum[ACCW-1] ? OUT_MIN_S : OUT_MAX_S;
    end else begin
      clamp_hit = |acc_sum[ACCW-1:AW];
      if (clamp_hit) sum_fin = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_ACC;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == S_OUT && out_ready) state_next = S_ACC;
    if (accept && in_last)           state_next = S_OUT;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc        <= '0;
      acc_ovf    <= 1'b0;
      cnt        <= '0;
      grp_signed <= 1'b0;
      sum_out    <= '0;
      sat_flag   <= 1'b0;
      beat_count <= '0;
    end else if (accept) begin
      if (cnt == '0) grp_signed <= op_signed;
      if (in_last) begin
        sum_out    <= sum_fin;
        sat_flag   <= clamp_hit | acc_ovf | ovf;
        beat_count <= cnt_inc;
        acc        <= '0;
        acc_ovf    <= 1'b0;
        cnt        <= '0;
      end else begin
        acc        <= acc_sum;
        acc_ovf    <= acc_ovf | ovf;
        cnt        <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_mac4x16_dot_reduce.sv
// Scoreboard bench for mac4x16_dot_reduce: directed beats push expected group
// results; a negedge monitor pops and compares on every output transfer.
module tb_mac4x16_dot_reduce;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] y_vec = '0;
  logic [3:0]   lane_mask = '0;
  logic         op_signed = 1'b0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [31:0]  sum_out;
  logic         sat_flag;
  logic [15:0]  beat_count;

  typedef struct packed {
    logic [31:0] sum;
    logic        sat;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  mac4x16_dot_reduce #(.LANES(4), .AW(32), .ACCW(40), .CNTW(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .y_vec      (y_vec),
    .lane_mask  (lane_mask),
    .op_signed  (op_signed),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sum_out    (sum_out),
    .sat_flag   (sat_flag),
    .beat_count (beat_count)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] lanes(input logic [31:0] a3, input logic [31:0] a2,
                                         input logic [31:0] a1, input logic [31:0] a0);
    return {a3, a2, a1, a0};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic expectResult(input logic [31:0] sum, input logic sat, input logic [15:0] cnt);
    exp_t e;
    e.sum = sum;
    e.sat = sat;
    e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  // Holds one beat on the inputs until it is accepted; returns just after that edge.
  task automatic applyStimulus(input logic [127:0] y, input logic [3:0] m,
                               input logic s, input logic l);
    bit done;
    done      = 1'b0;
    y_vec     = y;
    lane_mask = m;
    op_signed = s;
    in_last   = l;
    in_valid  = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 for 50 cycles expected acceptance");
    end
  endtask

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_result: got sum 0x%08h expected no result", sum_out);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("sum_out", sum_out, mon_e.sum);
        checkOutput("sat_flag", {31'b0, sat_flag}, {31'b0, mon_e.sat});
        checkOutput("beat_count", {16'b0, beat_count}, {16'b0, mon_e.cnt});
      end
    end
  end

  initial begin
    bit drained;

    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("rst_sum_out", sum_out, 32'd0);
    checkOutput("rst_sat_flag", {31'b0, sat_flag}, 32'd0);
    checkOutput("rst_beat_count", {16'b0, beat_count}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Single unsigned beat: 4+3+2+1.
    expectResult(32'd10, 1'b0, 16'd1);
    applyStimulus(lanes(4, 3, 2, 1), 4'b1111, 1'b0, 1'b1);
    checkOutput("latency_out_valid", {31'b0, out_valid}, 32'd1);

    // Lane1 masked: (-5+7+2) + (-10) + 100 = 94.
    expectResult(32'd94, 1'b0, 16'd3);
    applyStimulus(lanes(-5, 7, 1, 2), 4'b1101, 1'b1, 1'b0);
    applyStimulus(lanes(0, 0, 0, -10), 4'b1101, 1'b1, 1'b0);
    applyStimulus(lanes(100, 0, 0, 0), 4'b1101, 1'b1, 1'b1);

    expectResult(32'h7FFF_FFFF, 1'b1, 16'd2);
    applyStimulus({4{32'h7FFF_FFFF}}, 4'b1111, 1'b1, 1'b0);
    applyStimulus({4{32'h7FFF_FFFF}}, 4'b1111, 1'b1, 1'b1);
    expectResult(32'h8000_0000, 1'b1, 16'd2);
    applyStimulus({4{32'h8000_0000}}, 4'b1111, 1'b1, 1'b0);
    applyStimulus({4{32'h8000_0000}}, 4'b1111, 1'b1, 1'b1);

    // An all-masked beat still counts toward beat_count.
    expectResult(32'd6, 1'b0, 16'd2);
    applyStimulus(lanes(1, 2, 3, 4), 4'b0000, 1'b0, 1'b0);
    applyStimulus(lanes(0, 0, 0, 6), 4'b0001, 1'b0, 1'b1);

    expectResult(32'd1, 1'b0, 16'd1);
    expectResult(32'd2, 1'b0, 16'd1);
    applyStimulus(lanes(0, 0, 0, 1), 4'b0001, 1'b0, 1'b1);
    applyStimulus(lanes(0, 0, 0, 2), 4'b0001, 1'b0, 1'b1);
    checkOutput("b2b_out_valid", {31'b0, out_valid}, 32'd1);
    repeat (2) @(posedge clk);
    #1;

    out_ready = 1'b0;
    expectResult(32'd3, 1'b0, 16'd1);
    applyStimulus(lanes(0, 0, 0, 3), 4'b0001, 1'b0, 1'b1);
    y_vec     = lanes(0, 0, 0, 7);
    lane_mask = 4'b0001;
    op_signed = 1'b0;
    in_last   = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("stall_in_ready", {31'b0, in_ready}, 32'd0);
      checkOutput("stall_out_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("stall_sum_out", sum_out, 32'd3);
      checkOutput("stall_beat_count", {16'b0, beat_count}, 32'd1);
    end
    @(posedge clk);
    #1;
    expectResult(32'd7, 1'b0, 16'd1);
    out_ready = 1'b1;
    applyStimulus(lanes(0, 0, 0, 7), 4'b0001, 1'b0, 1'b1);
    checkOutput("bp_out_valid", {31'b0, out_valid}, 32'd1);

    // op_signed dropped on beat 2 must not change the group: -1 + -1.
    expectResult(32'hFFFF_FFFE, 1'b0, 16'd2);
    applyStimulus(lanes(0, 0, 0, -1), 4'b0001, 1'b1, 1'b0);
    applyStimulus(lanes(0, 0, 0, -1), 4'b0001, 1'b0, 1'b1);

    applyStimulus(lanes(0, 0, 0, 9), 4'b0001, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    rst = 1'b1;
    expectResult(32'd5, 1'b0, 16'd1);
    applyStimulus(lanes(0, 0, 0, 5), 4'b0001, 1'b0, 1'b1);

    expectResult(32'hFFFF_FFFF, 1'b1, 16'd2);
    applyStimulus({4{32'hFFFF_FFFF}}, 4'b1111, 1'b0, 1'b0);
    applyStimulus({4{32'hFFFF_FFFF}}, 4'b1111, 1'b0, 1'b1);

    drained = 1'b0;
    for (int k = 0; k < 100 && !drained; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) drained = 1'b1;
    end
    if (!drained) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain_timeout: got %0d results pending expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
